// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the round-robin arbiter and the FIFO write port.
// The slave modport is the arbiter; the master modport is the producers plus the FIFO.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_BITS    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic [ID_BITS+DATA_WIDTH-1:0] fifo_write_data;
    logic                          fifo_write_enable;
    logic                          busy;

    modport slave (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_write_data,
        output fifo_write_enable,
        output busy
    );

    modport master (
        output req_valid,
        output req_last,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_write_data,
        input  fifo_write_enable,
        input  busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Packets are locked to one producer until its last beat; each word is tagged {source_id, payload}.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fifo_write_arbiter_if.slave  bus
);

    if ((ID_BITS != $clog2(NUM_REQ)) || (NUM_REQ < 2) || (NUM_REQ > 16)) begin : g_param_err
        $error("fifo_write_arbiter: NUM_REQ must be 2..16 and ID_BITS must equal clog2(NUM_REQ)");
    end

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ID_BITS-1:0]    owner_q;
    logic [ID_BITS-1:0]    owner_d;
    logic [ID_BITS-1:0]    rr_ptr_q;
    logic [ID_BITS-1:0]    rr_ptr_d;

    logic [DATA_WIDTH-1:0] data_arr_s [NUM_REQ];
    logic                  found_s;
    logic [ID_BITS-1:0]    cand_s;
    logic [ID_BITS:0]      probe_s;
    logic [ID_BITS-1:0]    sel_s;
    logic                  elig_s;
    logic                  fire_s;
    logic                  last_s;

    // Pointer advance that wraps at NUM_REQ-1, not at the ID field's power of two.
    function automatic logic [ID_BITS-1:0] wrap_inc(input logic [ID_BITS-1:0] v);
        if (v == ID_BITS'(NUM_REQ - 1)) begin
            return '0;
        end else begin
            return v + ID_BITS'(1);
        end
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr_s[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating priority search: first valid requester at or after rr_ptr, modulo NUM_REQ.
    always_comb begin
        found_s = 1'b0;
        cand_s  = '0;
        probe_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe_s = {1'b0, rr_ptr_q} + (ID_BITS+1)'(k);
            if (probe_s >= (ID_BITS+1)'(NUM_REQ)) begin
                probe_s = probe_s - (ID_BITS+1)'(NUM_REQ);
            end else begin
                probe_s = probe_s;
            end
            if (!found_s && bus.req_valid[probe_s[ID_BITS-1:0]]) begin
                found_s = 1'b1;
                cand_s  = probe_s[ID_BITS-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant selection and the zero-latency handshake towards producers and FIFO.
    always_comb begin
        sel_s  = cand_s;
        elig_s = found_s;
        if (state_q == ST_LOCKED) begin
            sel_s  = owner_q;
            elig_s = bus.req_valid[owner_q];
        end else begin
            sel_s  = cand_s;
            elig_s = found_s;
        end
        fire_s = reset_n & elig_s & ~bus.fifo_full;
        last_s = bus.req_last[sel_s];
    end

    assign bus.req_ready         = fire_s ? (NUM_REQ'(1) << sel_s) : '0;
    assign bus.fifo_write_enable = fire_s;
    assign bus.fifo_write_data   = {sel_s, data_arr_s[sel_s]};
    assign bus.busy              = reset_n & (state_q == ST_LOCKED);

    // Next-state: a non-last beat takes the lock; the owner's last beat releases it and rotates priority.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (fire_s && last_s) begin
                    rr_ptr_d = wrap_inc(sel_s);
                end else if (fire_s) begin
                    state_d = ST_LOCKED;
                    owner_d = sel_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (fire_s && last_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = wrap_inc(owner_q);
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                owner_d  = '0;
                rr_ptr_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a 4-requester instance plus a 3-requester instance
// for the non-power-of-two wrap. Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_fifo_write_arbiter;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(DW), .ID_BITS(2)) bus4 ();
    fifo_write_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(DW), .ID_BITS(2)) bus3 ();

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .ID_BITS(2)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );
    fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .ID_BITS(2)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] d4 [4];
    logic [DW-1:0] d3 [3];

    task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic full);
        bus4.req_valid = v;
        bus4.req_last  = l;
        bus4.fifo_full = full;
    endtask

    task automatic set_data4(input int i, input logic [DW-1:0] d);
        d4[i] = d;
        bus4.req_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        bus3.req_valid = 3'b000;
        bus3.req_last  = 3'b000;
        bus3.fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d3[i] = 32'hC0C0_0000 | DW'(i);
            bus3.req_data[i*DW +: DW] = d3[i];
        end
        for (int i = 0; i < 4; i++) set_data4(i, 32'hA0A0_0000 | DW'(i));
        reset_n = 1'b0;
        drive4(4'hF, 4'hF, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus4.req_ready !== 4'b0000 || bus4.fifo_write_enable !== 1'b0 || bus4.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: ready=%b we=%b busy=%b, expected 0000/0/0",
                         c, bus4.req_ready, bus4.fifo_write_enable, bus4.busy);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive4(4'h0, 4'h0, 1'b0);
        #1;
        n_checks++;
        if (bus4.fifo_write_enable !== 1'b0 || bus4.busy !== 1'b0 || bus3.fifo_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: we4=%b busy4=%b we3=%b, expected 0/0/0",
                     bus4.fifo_write_enable, bus4.busy, bus3.fifo_write_enable);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  id;
        logic [33:0] exp_wd;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive4(4'hF, 4'hF, 1'b0);
            #1;
            id     = 2'(k % 4);
            exp_wd = {id, d4[id]};
            n_checks++;
            if (bus4.fifo_write_enable !== 1'b1 || bus4.req_ready !== (4'b0001 << id) ||
                bus4.fifo_write_data !== exp_wd) begin
                n_fail++;
                $display("FAIL rr_grant beat %0d: we=%b ready=%b wdata=%h, expected 1/%b/%h",
                         k, bus4.fifo_write_enable, bus4.req_ready, bus4.fifo_write_data,
                         4'b0001 << id, exp_wd);
            end
        end
    endtask

    task automatic test_locked_packet();
        logic [3:0]  vv [6];
        logic [3:0]  ll [6];
        logic [1:0]  ids [6];
        logic        bsy [6];
        logic [33:0] exp_wd;
        vv  = '{4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b0111, 4'b0011};
        ll  = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0111, 4'b0011};
        ids = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
        bsy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_data4(2, 32'h2222_0000 | DW'(k));
            drive4(vv[k], ll[k], 1'b0);
            #1;
            exp_wd = {ids[k], d4[ids[k]]};
            n_checks++;
            if (bus4.fifo_write_enable !== 1'b1 || bus4.req_ready !== (4'b0001 << ids[k]) ||
                bus4.fifo_write_data !== exp_wd || bus4.busy !== bsy[k]) begin
                n_fail++;
                $display("FAIL locked_packet step %0d: we=%b ready=%b wdata=%h busy=%b, expected 1/%b/%h/%b",
                         k, bus4.fifo_write_enable, bus4.req_ready, bus4.fifo_write_data, bus4.busy,
                         4'b0001 << ids[k], exp_wd, bsy[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        set_data4(1, 32'hDEAD_BEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive4(4'b0010, 4'b0010, 1'b1);
            #1;
            n_checks++;
            if (bus4.fifo_write_enable !== 1'b0 || bus4.req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL backpressure_stall cycle %0d: we=%b ready=%b, expected 0/0000",
                         k, bus4.fifo_write_enable, bus4.req_ready);
            end
        end
        @(negedge clk);
        drive4(4'b0010, 4'b0010, 1'b0);
        #1;
        n_checks++;
        if (bus4.fifo_write_enable !== 1'b1 || bus4.req_ready !== 4'b0010 ||
            bus4.fifo_write_data !== {2'd1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL backpressure_release: we=%b ready=%b wdata=%h, expected 1/0010/1deadbeef",
                     bus4.fifo_write_enable, bus4.req_ready, bus4.fifo_write_data);
        end
    endtask

    task automatic test_owner_gap();
        logic [3:0] exp_rdy;
        @(negedge clk);
        drive4(4'b0001, 4'b0000, 1'b0);
        #1;
        n_checks++;
        if (bus4.req_ready !== 4'b0001 || bus4.fifo_write_data !== {2'd0, d4[0]}) begin
            n_fail++;
            $display("FAIL gap_first_beat: ready=%b wdata=%h, expected 0001/%h",
                     bus4.req_ready, bus4.fifo_write_data, {2'd0, d4[0]});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive4(4'b1000, 4'b1000, 1'b0);
            #1;
            n_checks++;
            if (bus4.fifo_write_enable !== 1'b0 || bus4.req_ready !== 4'b0000 || bus4.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_hold cycle %0d: we=%b ready=%b busy=%b, expected 0/0000/1",
                         k, bus4.fifo_write_enable, bus4.req_ready, bus4.busy);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) drive4(4'b1001, 4'b1000, 1'b0);
            else if (k == 1) drive4(4'b1001, 4'b1001, 1'b0);
            else drive4(4'b1000, 4'b1000, 1'b0);
            #1;
            exp_rdy = (k < 2) ? 4'b0001 : 4'b1000;
            n_checks++;
            if (bus4.fifo_write_enable !== 1'b1 || bus4.req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL gap_resume step %0d: we=%b ready=%b, expected 1/%b",
                         k, bus4.fifo_write_enable, bus4.req_ready, exp_rdy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive4(4'b0110, (k == 0) ? 4'b0100 : 4'b0110, 1'b0);
            #1;
            exp_rdy = (k < 2) ? 4'b0010 : 4'b0100;
            n_checks++;
            if (bus4.fifo_write_enable !== 1'b1 || bus4.req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL back_to_back beat %0d: we=%b ready=%b, expected 1/%b",
                         k, bus4.fifo_write_enable, bus4.req_ready, exp_rdy);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        @(negedge clk);
        drive4(4'b1000, 4'b0000, 1'b0);
        #1;
        n_checks++;
        if (bus4.req_ready !== 4'b1000 || bus4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_beat1: ready=%b busy=%b, expected 1000/0", bus4.req_ready, bus4.busy);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus4.req_ready !== 4'b0000 || bus4.fifo_write_enable !== 1'b0 || bus4.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_during: ready=%b we=%b busy=%b, expected 0000/0/0",
                     bus4.req_ready, bus4.fifo_write_enable, bus4.busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive4(4'hF, 4'hF, 1'b0);
        #1;
        n_checks++;
        if (bus4.busy !== 1'b0 || bus4.req_ready !== 4'b0001 || bus4.fifo_write_data !== {2'd0, d4[0]}) begin
            n_fail++;
            $display("FAIL midreset_after: busy=%b ready=%b wdata=%h, expected 0/0001/%h",
                     bus4.busy, bus4.req_ready, bus4.fifo_write_data, {2'd0, d4[0]});
        end
        @(negedge clk);
        drive4(4'h0, 4'h0, 1'b0);
    endtask

    task automatic test_nonpow2();
        logic [1:0]  id;
        logic [33:0] exp_wd;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus3.req_valid = 3'b111;
            bus3.req_last  = 3'b111;
            bus3.fifo_full = 1'b0;
            #1;
            id     = 2'(k % 3);
            exp_wd = {id, d3[id]};
            n_checks++;
            if (bus3.fifo_write_enable !== 1'b1 || bus3.req_ready !== (3'b001 << id) ||
                bus3.fifo_write_data !== exp_wd) begin
                n_fail++;
                $display("FAIL nonpow2_grant beat %0d: we=%b ready=%b wdata=%h, expected 1/%b/%h",
                         k, bus3.fifo_write_enable, bus3.req_ready, bus3.fifo_write_data,
                         3'b001 << id, exp_wd);
            end
        end
        @(negedge clk);
        bus3.req_valid = 3'b000;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_locked_packet();
        test_backpressure();
        test_owner_gap();
        test_back_to_back();
        test_reset_mid_packet();
        test_nonpow2();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares a single FIFO write port between NUM_REQ independent producers.
- Each producer presents beats with valid/ready/last. Multi-beat packets are locked to one producer until the beat with last set, so packets never interleave in the FIFO.
- Each written FIFO word carries the source ID in its top bits, so the consumer can demultiplex.
- Sits directly in front of the team's synchronous FIFO and drives its write_data and write_enable from that FIFO's full flag.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 32, payload bits per beat.
- ID_BITS, 2, source-ID width; must equal clog2(NUM_REQ); checked by an elaboration-time assertion.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_last  input  NUM_REQ  per-requester last-beat-of-packet flag, qualified by req_valid.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot or zero; beat i transfers on a cycle where req_valid[i] and req_ready[i] are both 1.
- fifo_full  input  1  full flag from the FIFO.
- fifo_write_data  output  ID_BITS+DATA_WIDTH  {source_id, payload}.
- fifo_write_enable  output  1  FIFO write strobe.
- busy  output  1  high while in LOCKED.

Behaviour:
- State
  - state: IDLE or LOCKED.
  - owner: ID_BITS, the requester holding the lock.
  - rr_ptr: ID_BITS, the highest-priority requester for the next arbitration.
  - Reset values: state=IDLE, owner=0, rr_ptr=0.
- Outputs are combinational from state and inputs, so a beat is accepted in the same cycle it is presented (zero-latency accept).
- While reset_n=0:
  - req_ready=0, fifo_write_enable=0, busy=0.
  - fifo_write_data is don't-care.
- IDLE
  - Candidate = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If no candidate or fifo_full=1: req_ready=0, no write, no state change.
  - Otherwise: req_ready[cand]=1, fifo_write_enable=1, fifo_write_data={cand, req_data[cand]}.
  - If req_last[cand]=1: stay in IDLE, rr_ptr<=cand+1 (mod NUM_REQ).
  - If req_last[cand]=0: state<=LOCKED, owner<=cand, rr_ptr unchanged.
- LOCKED
  - Only the owner is eligible; all other req_ready bits are 0 regardless of their valid.
  - Owner beat transfers when req_valid[owner]=1 and fifo_full=0; the write is performed as in IDLE.
  - On a transferred beat with req_last[owner]=1: state<=IDLE, rr_ptr<=owner+1 (mod NUM_REQ).
  - Owner deasserting valid mid-packet: stay LOCKED and wait indefinitely. There is no timeout.
- Backpressure
  - fifo_write_enable is never 1 while fifo_full=1.
  - A stalled beat's data is not captured. The requester must hold valid, data and last stable until ready.
- Wrap-around
  - rr_ptr increments modulo NUM_REQ.
  - For non-power-of-two NUM_REQ, NUM_REQ-1 wraps to 0, not to 2^ID_BITS-1.
- Fairness: a continuously-valid requester waits at most NUM_REQ-1 packets from other requesters before being granted.
- Reset mid-packet: reset while LOCKED returns to IDLE immediately. The partially written packet stays in the FIFO. Flushing it is the consumer's responsibility.
- Throughput: one beat per cycle, including back-to-back packets from different requesters. No idle cycle is inserted at packet boundaries.

Test Plan:
- After reset, all req_valid=1 with last=1, fifo_full=0, for 8 cycles -> writes with source IDs 0,1,2,3,0,1,2,3, one per cycle; req_ready one-hot each cycle.
- Requester 2 sends a 3-beat packet (last on beat 3) while requesters 0 and 1 hold valid -> three consecutive writes tagged ID 2, busy=1 after beat 1, then next grant goes to ID 3 if valid, else ID 0.
- fifo_full=1 for 5 cycles with requester 1 valid, data 0xDEADBEEF -> fifo_write_enable=0 and req_ready=0 throughout; the write occurs in the first cycle fifo_full=0, with fifo_write_data={1, 0xDEADBEEF}.
- Owner 0 drops valid for 4 cycles mid-packet while requester 3 is valid -> no writes and req_ready[3]=0 during the gap; owner resumes and completes its packet before ID 3 is granted.
- NUM_REQ=3, ID_BITS=2, all valid with last=1 -> ID sequence 0,1,2,0,1,2; ID 3 never appears.
- reset_n=0 asserted during beat 2 of a 4-beat packet -> next cycle busy=0, rr_ptr=0; after release, requester 0 is granted first if valid.
